// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - exhaustive truth-table self-check sequencer for one N-input gate
module gate_truth_table_sequencer #(
  parameter int                     N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]   TRUTH  = 4'b1110,
  parameter int                     SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    dut_y,
  output logic [N_IN-1:0]         dut_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [(2**N_IN)-1:0]    fail_mask
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic [NV-1:0]   sampled_mask;

  // Mask as it will look once the current vector's result is written, so the
  // final pass decision already includes the last sample.
  always_comb begin
    mismatch          = (dut_y != TRUTH[idx]);
    sampled_mask      = fail_mask;
    sampled_mask[idx] = mismatch;
  end

  // Run FSM: step through every input vector, hold each SETTLE cycles, record mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            fail_mask <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial fail_mask is kept so a supervisor can see how far the run got.
            state  <= IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
            pass   <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            fail_mask <= sampled_mask;
            cnt       <= '0;
            if (idx != IDX_LAST) begin
              idx    <= idx + 1'b1;
              dut_in <= idx + 1'b1;
            end else begin
              state  <= DONE;
              dut_in <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= ~|sampled_mask;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb/tb_gate_truth_table_sequencer.sv - self-checking bench for gate_truth_table_sequencer
module tb_gate_truth_table_sequencer;

  localparam int N_IN   = 2;
  localparam int NV     = 4;
  localparam int SETTLE = 2;
  localparam int RUN_EDGES = NV * SETTLE;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            dut_y;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NV-1:0]   fail_mask;

  // Gate under check: its truth table, indexed by input vector.
  logic [NV-1:0]   gate_tbl = 4'b1110;

  int n_assert = 0;
  int n_fail   = 0;

  assign dut_y = gate_tbl[dut_in];

  always #5 clk = ~clk;

  gate_truth_table_sequencer #(
    .N_IN   (N_IN),
    .TRUTH  (4'b1110),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .dut_y     (dut_y),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the checked gate is expected to behave as OR, so vector k expects y = (k != 0).
  function automatic logic [NV-1:0] model_mask(input logic [NV-1:0] g);
    logic [NV-1:0] m;
    for (int k = 0; k < NV; k++) m[k] = (g[k] != (k != 0));
    return m;
  endfunction

  function automatic logic [NV-1:0] low_bits(input logic [NV-1:0] m, input int n);
    logic [NV-1:0] r;
    for (int k = 0; k < NV; k++) r[k] = (k < n) ? m[k] : 1'b0;
    return r;
  endfunction

  task automatic check_all(input string tag, input logic [N_IN-1:0] e_in, input logic e_busy,
                           input logic e_done, input logic e_pass, input logic [NV-1:0] e_mask);
    check({tag, ".dut_in"},    dut_in,    e_in);
    check({tag, ".busy"},      busy,      e_busy);
    check({tag, ".done"},      done,      e_done);
    check({tag, ".pass"},      pass,      e_pass);
    check({tag, ".fail_mask"}, fail_mask, e_mask);
  endtask

  // One run: start at a negedge, then follow each edge. stop_at>0 injects abort
  // (or rst) so it is sampled at edge stop_at after the start edge.
  task automatic run(input string tag, input logic [NV-1:0] g, input int stop_at,
                     input bit use_rst, input bit repulse, input bit abort_w_start);
    logic [NV-1:0] em;
    logic          ep;
    int            nsamp;
    em = model_mask(g);
    ep = (em == '0);
    gate_tbl = g;
    start = 1'b1;
    abort = abort_w_start;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_all($sformatf("%s.e0", tag), '0, 1'b1, 1'b0, 1'b0, '0);
    for (int j = 1; j <= RUN_EDGES + 1; j++) begin
      if (repulse && (j == 3 || j == 7 || j == RUN_EDGES + 1)) start = 1'b1;
      if (stop_at == j) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (stop_at == j) begin
        nsamp = (j - 1) / SETTLE;
        if (use_rst) check_all($sformatf("%s.rst%0d", tag, j), '0, 1'b0, 1'b0, 1'b0, '0);
        else check_all($sformatf("%s.abort%0d", tag, j), '0, 1'b0, 1'b0, 1'b0, low_bits(em, nsamp));
        for (int q = 0; q < 3; q++) begin
          @(posedge clk); @(negedge clk);
          check($sformatf("%s.quiet%0d.done", tag, q), done, 1'b0);
          check($sformatf("%s.quiet%0d.busy", tag, q), busy, 1'b0);
        end
        return;
      end
      if (j < RUN_EDGES)
        check_all($sformatf("%s.e%0d", tag, j), N_IN'(j / SETTLE), 1'b1, 1'b0, 1'b0,
                  low_bits(em, j / SETTLE));
      else if (j == RUN_EDGES)
        check_all($sformatf("%s.done", tag), '0, 1'b0, 1'b1, ep, em);
      else
        check_all($sformatf("%s.after", tag), '0, 1'b0, 1'b0, ep, em);
    end
  endtask

  initial begin
    logic [NV-1:0] g;
    int            sa;
    bit            ur;
    rst = 1'b1;
    abort = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_all("reset", '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    abort = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all("idle", '0, 1'b0, 1'b0, 1'b0, '0);

    run("or",      4'b1110, 0, 1'b0, 1'b0, 1'b0);
    run("and",     4'b1000, 0, 1'b0, 1'b0, 1'b0);
    run("repulse", 4'b1110, 0, 1'b0, 1'b1, 1'b0);
    run("abort",   4'b1000, 5, 1'b0, 1'b0, 1'b0);
    run("rstmid",  4'b1000, 3, 1'b1, 1'b0, 1'b0);
    run("or2",     4'b1110, 0, 1'b0, 1'b0, 1'b0);
    run("and2",    4'b1000, 0, 1'b0, 1'b0, 1'b0);
    run("xor_sa",  4'b0110, 0, 1'b0, 1'b0, 1'b1);
    run("abort_last", 4'b0001, RUN_EDGES, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      g  = NV'($urandom);
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUN_EDGES) : 0;
      ur = 1'($urandom);
      run($sformatf("rand%0d", r), g, sa, ur, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
